// File: rtl/prog_lut_cfg_if.sv
// Bus bundle for prog_lut_cfg: lookup request/response plus the serial
// table-reload channel. The master drives requests and config bits; the
// LUT (slave) returns results and reload status.
interface prog_lut_cfg_if #(
  parameter int N = 5
);
  logic         in_valid;
  logic [N-1:0] in_addr;
  logic         out_valid;
  logic         out_y;
  logic         cfg_start;
  logic         cfg_bit_v;
  logic         cfg_bit;
  logic         cfg_busy;
  logic         cfg_done;

  modport master (
    output in_valid, in_addr, cfg_start, cfg_bit_v, cfg_bit,
    input  out_valid, out_y, cfg_busy, cfg_done
  );

  modport slave (
    input  in_valid, in_addr, cfg_start, cfg_bit_v, cfg_bit,
    output out_valid, out_y, cfg_busy, cfg_done
  );
endinterface

// File: rtl/prog_lut_cfg.sv
// Run-time programmable N-input LUT with registered output.
// New contents are shifted serially into a shadow register (entry 0 first)
// and copied into the active table in a single COMMIT cycle, so lookups
// never see a partially written table.
//
// state  | meaning
// IDLE   | waiting for cfg_start; cfg_bit_v ignored
// LOAD   | shifting config bits into the shadow register
// COMMIT | shadow copied to active table, cfg_done high
module prog_lut_cfg #(
  parameter int                  N    = 5,
  parameter logic [(2**N)-1:0]   INIT = 32'h7BE64D5E
) (
  input  logic          clk,
  input  logic          rst,
  prog_lut_cfg_if.slave bus
);

  localparam int         DEPTH = 2**N;
  localparam logic [N:0] LAST  = (N+1)'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, LOAD, COMMIT} state_t;

  state_t           state, state_nx;
  logic [DEPTH-1:0] lut_q;
  logic [DEPTH-1:0] shadow;
  logic [N:0]       cnt;
  logic             bit_wr;

  // Next-state decode; the write that fills the last entry ends LOAD.
  always_comb begin
    state_nx = state;
    bit_wr   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.cfg_start) state_nx = LOAD;
      end
      LOAD: begin
        bit_wr = bus.cfg_bit_v;
        if (bus.cfg_bit_v && (cnt == LAST)) state_nx = COMMIT;
      end
      COMMIT: begin
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Shadow fill and bit counter; counter restarts on each accepted cfg_start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow <= '0;
      cnt    <= '0;
    end else if ((state == IDLE) && bus.cfg_start) begin
      cnt <= '0;
    end else if (bit_wr) begin
      shadow[cnt[N-1:0]] <= bus.cfg_bit;
      cnt                <= cnt + 1'b1;
    end
  end

  // Active table: whole-table copy in COMMIT only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  lut_q <= INIT;
    else if (state == COMMIT) lut_q <= shadow;
  end

  // Lookup path; reads the pre-commit table in the COMMIT cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.out_y     <= 1'b0;
    end else begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid) bus.out_y <= lut_q[bus.in_addr];
    end
  end

  assign bus.cfg_busy = (state != IDLE);
  assign bus.cfg_done = (state == COMMIT);

endmodule

// File: tb/tb_prog_lut_cfg.sv
// Randomized bench for prog_lut_cfg: an N=5 default instance and an N=3
// instance share the lookup stimulus; reload traffic is steered to one of
// them per cycle. Expected outputs come from a table-level model.
module tb_prog_lut_cfg;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  prog_lut_cfg_if #(.N(5)) if5 ();
  prog_lut_cfg_if #(.N(3)) if3 ();

  prog_lut_cfg #(.N(5), .INIT(32'h7BE64D5E)) dut5 (.clk(clk), .rst(rst), .bus(if5.slave));
  prog_lut_cfg #(.N(3), .INIT(8'hA5))        dut3 (.clk(clk), .rst(rst), .bus(if3.slave));

  int n_chk  = 0;
  int n_fail = 0;

  // Model state per instance (0: N=5, 1: N=3)
  logic [31:0] m_tbl [2];
  logic [31:0] m_new [2];
  int          m_cnt [2];
  bit          m_load [2];
  bit          m_commit [2];
  logic        exp_y [2];
  logic        exp_valid [2];
  int          done_seen [2];
  int          depth [2] = '{32, 8};

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reset table derived from the documented OFF set.
  function automatic logic [31:0] init5();
    logic [31:0] t;
    int off [12] = '{0, 5, 7, 9, 12, 13, 15, 16, 19, 20, 26, 31};
    t = '1;
    foreach (off[k]) t[off[k]] = 1'b0;
    return t;
  endfunction

  function automatic logic [31:0] init3();
    logic [31:0] t;
    bit seq [8] = '{1, 0, 1, 0, 0, 1, 0, 1};
    t = '0;
    foreach (seq[k]) t[k] = seq[k];
    return t;
  endfunction

  function automatic void model_reset();
    m_tbl[0] = init5();
    m_tbl[1] = init3();
    for (int i = 0; i < 2; i++) begin
      m_new[i]     = '0;
      m_cnt[i]     = 0;
      m_load[i]    = 1'b0;
      m_commit[i]  = 1'b0;
      exp_y[i]     = 1'b0;
      exp_valid[i] = 1'b0;
    end
  endfunction

  task automatic check_outs(input string tag);
    check_eq({tag, "_valid5"}, 32'(if5.out_valid), 32'(exp_valid[0]));
    check_eq({tag, "_y5"},     32'(if5.out_y),     32'(exp_y[0]));
    check_eq({tag, "_busy5"},  32'(if5.cfg_busy),  32'(m_load[0] | m_commit[0]));
    check_eq({tag, "_done5"},  32'(if5.cfg_done),  32'(m_commit[0]));
    check_eq({tag, "_valid3"}, 32'(if3.out_valid), 32'(exp_valid[1]));
    check_eq({tag, "_y3"},     32'(if3.out_y),     32'(exp_y[1]));
    check_eq({tag, "_busy3"},  32'(if3.cfg_busy),  32'(m_load[1] | m_commit[1]));
    check_eq({tag, "_done3"},  32'(if3.cfg_done),  32'(m_commit[1]));
  endtask

  task automatic drive_idle();
    if5.in_valid = 1'b0; if5.in_addr = '0; if5.cfg_start = 1'b0; if5.cfg_bit_v = 1'b0; if5.cfg_bit = 1'b0;
    if3.in_valid = 1'b0; if3.in_addr = '0; if3.cfg_start = 1'b0; if3.cfg_bit_v = 1'b0; if3.cfg_bit = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive_idle();
    rst = 1'b1;
    #1;
    model_reset();
    check_outs("reset");
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One clock: apply inputs, advance the model across the edge, compare.
  task automatic cyc(input logic v, input logic [4:0] a, input logic st,
                     input logic bv, input logic b, input int sel);
    logic st_i, bv_i;
    int   idx;
    @(negedge clk);
    if5.in_valid = v; if5.in_addr = a;
    if3.in_valid = v; if3.in_addr = a[2:0];
    if5.cfg_start = st & (sel == 0); if5.cfg_bit_v = bv & (sel == 0); if5.cfg_bit = b;
    if3.cfg_start = st & (sel == 1); if3.cfg_bit_v = bv & (sel == 1); if3.cfg_bit = b;
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      st_i = st & (sel == i);
      bv_i = bv & (sel == i);
      idx  = (i == 0) ? int'(a) : int'(a[2:0]);
      exp_valid[i] = v;
      if (v) exp_y[i] = m_tbl[i][idx];
      if (m_commit[i]) begin
        m_tbl[i]    = m_new[i];
        m_commit[i] = 1'b0;
      end else if (m_load[i]) begin
        if (bv_i) begin
          m_new[i][m_cnt[i]] = b;
          m_cnt[i]++;
          if (m_cnt[i] == depth[i]) begin
            m_load[i]   = 1'b0;
            m_commit[i] = 1'b1;
          end
        end
      end else if (st_i) begin
        m_load[i] = 1'b1;
        m_cnt[i]  = 0;
      end
    end
    #1;
    check_outs("cyc");
    if (if5.cfg_done) done_seen[0]++;
    if (if3.cfg_done) done_seen[1]++;
  endtask

  task automatic sweep(input int n);
    for (int k = 0; k < n; k++) cyc(1'b1, 5'(k), 1'b0, 1'b0, 1'b0, 0);
    cyc(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 0);
  endtask

  // Start a reload, send n bits with random gaps, then let COMMIT finish.
  task automatic load(input int sel, input logic [31:0] data, input int n, input int max_gap,
                      input logic v, input logic [4:0] a, input logic st_gap);
    cyc(v, a, 1'b1, 1'b0, 1'b0, sel);
    for (int k = 0; k < n; k++) begin
      int g;
      g = $urandom_range(0, max_gap);
      for (int j = 0; j < g; j++) cyc(v, a, st_gap, 1'b0, 1'b0, sel);
      cyc(v, a, 1'b0, 1'b1, data[k], sel);
    end
    cyc(v, a, 1'b0, 1'b0, 1'b0, sel);
    cyc(v, a, 1'b0, 1'b0, 1'b0, sel);
  endtask

  initial begin
    drive_idle();
    model_reset();

    // Reset contents of both instances
    do_reset();
    sweep(32);

    // Single-bit pattern with gaps; exactly one cfg_done pulse
    done_seen[0] = 0;
    load(0, 32'h0000_0001, 32, 2, 1'b0, 5'd0, 1'b0);
    check_eq("t2_done_pulses", 32'(done_seen[0]), 32'd1);
    sweep(32);

    // Continuous addr-5 lookups across a reload to all ones
    load(0, 32'hFFFF_FFFF, 32, 1, 1'b1, 5'd5, 1'b0);
    cyc(1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 0);

    // Reset in the middle of a reload, then a full reload
    do_reset();
    cyc(1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 0);
    for (int k = 0; k < 17; k++) cyc(1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 0);
    do_reset();
    check_eq("t4_busy_after_rst", 32'(if5.cfg_busy), 32'd0);
    cyc(1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 0);
    cyc(1'b1, 5'd1, 1'b0, 1'b0, 1'b0, 0);
    check_eq("t4_addr1", 32'(if5.out_y), 32'd1);
    load(0, $urandom, 32, 1, 1'b0, 5'd0, 1'b0);
    sweep(32);

    // Strobes in the wrong state have no effect
    for (int k = 0; k < 4; k++) cyc(1'b1, 5'($urandom), 1'b0, 1'b1, 1'($urandom), 0);
    load(0, $urandom, 32, 2, 1'b1, 5'($urandom), 1'b1);
    sweep(32);

    // N=3 instance: reset sweep, then reload 8'h0F
    sweep(8);
    load(1, 32'h0000_000F, 8, 1, 1'b0, 5'd0, 1'b0);
    sweep(8);

    // Random traffic on both instances
    for (int k = 0; k < 800; k++)
      cyc(1'($urandom), 5'($urandom), 1'($urandom_range(0, 7) == 0),
          1'($urandom), 1'($urandom), int'($urandom_range(0, 1)));
    for (int k = 0; k < 80; k++)
      cyc(1'b0, 5'd0, 1'b0, 1'b1, 1'($urandom), 0);
    for (int k = 0; k < 20; k++)
      cyc(1'b0, 5'd0, 1'b0, 1'b1, 1'($urandom), 1);
    sweep(32);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
